axis_tpg_mc: RTL and testbench
==============================

Name: axis_tpg_mc

Overview:
- Next-generation AXI4-Stream test pattern generator.
- Emits CHANNELS pixels per beat with full AXIS backpressure compliance.
- Supports programmable horizontal/vertical blanking, enable-gated frame start/stop, and an extended pattern set (colour bars, fixed colour, moving box).
- Sits at the head of the video pipeline as a stand-in camera source for the downstream 3DNR/VDMA path.

Parameters:
- DATA_WIDTH, 16, bits per pixel lane.
- CHANNELS, 1, pixels per beat; tdata width = DATA_WIDTH*CHANNELS; lane k carries pixel x+k.
- CHESS_WPOW, 4, log2 chess/bar/box horizontal cell size.
- CHESS_HPOW, 4, log2 chess/box vertical cell size.

Ports:
- m_axis_aclk, in, 1, sole clock.
- rst_n, in, 1, asynchronous active-low reset.
- enable, in, 1, run request; sampled at frame boundaries.
- ACTIVE_WIDTH, in, 16, pixels per line.
- ACTIVE_HEIGHT, in, 16, lines per frame.
- HBLANK, in, 16, idle cycles after each non-final line.
- VBLANK, in, 16, idle cycles after each frame.
- tpg_mode, in, 4, pattern select.
- fixed_color, in, DATA_WIDTH, colour for modes 7/8.
- m_axis_tdata, out, DATA_WIDTH*CHANNELS, pixel data.
- m_axis_tlast, out, 1, last beat of line.
- m_axis_tuser, out, 1, first beat of frame.
- m_axis_tvalid, out, 1, beat valid.
- m_axis_tready, in, 1, downstream ready.
- frame_cnt, out, 16, completed-frame counter.
- busy, out, 1, high when state != IDLE.

Behaviour:
- Clock and reset: one clock, m_axis_aclk. rst_n is asynchronous, active-low.
- Reset values: all outputs 0, state IDLE, internal x/y/box counters 0.
- All outputs are registered.
- FSM states: IDLE, ACTIVE, HBLANK, VBLANK.
- IDLE:
  - tvalid=0.
  - If enable=1 and latched ACTIVE_WIDTH!=0 and ACTIVE_HEIGHT!=0, go to ACTIVE.
  - The first beat (x=0, y=0, tuser=1) appears the cycle after enable is sampled high.
  - Zero width or height: stay IDLE.
- Config shadowing:
  - ACTIVE_WIDTH, ACTIVE_HEIGHT, HBLANK, VBLANK, tpg_mode and fixed_color are latched on every frame start.
  - Mid-frame changes take effect at the next frame.
- AXIS rules:
  - tdata/tlast/tuser are held stable while tvalid=1 and tready=0.
  - tvalid never drops without a handshake.
  - A handshake is tvalid and tready.
- ACTIVE, on each handshake:
  - x += CHANNELS.
  - tlast=1 on the beat where x+CHANNELS >= width.
  - Lanes whose pixel index is >= width output 0.
- After the tlast handshake:
  - Non-final line: if HBLANK=0, next line is back-to-back; otherwise HBLANK for exactly HBLANK cycles with tvalid=0, then ACTIVE.
  - Final line: frame_cnt += 1 (wraps at 2^16), then VBLANK for VBLANK cycles (0 = none).
  - At the end of VBLANK: if enable=1, new frame in ACTIVE; else IDLE.
- enable low mid-frame: the current frame always completes; no truncated frames.
- Patterns, per lane, pixel (px,py), fc = frame_cnt:
  - 0: chess; all ones when px[CHESS_WPOW]==py[CHESS_HPOW], else 0.
  - 1: px.
  - 2: py.
  - 3: px+fc.
  - 4: py+fc.
  - 5: all ones.
  - 6: bars; bar = px[CHESS_WPOW+2:CHESS_WPOW], output {bar, zeros} MSB-justified.
  - 7: fixed_color.
  - 8: moving box; fixed_color inside a 2^CHESS_WPOW x 2^CHESS_HPOW box at (bx,by), else 0.
  - Others: 0.
- Arithmetic is modulo 2^DATA_WIDTH (truncate). Counters are 16 bit.
- Box motion, updated at each frame end:
  - bx+1; wraps to 0 when bx+1+2^CHESS_WPOW > width.
  - Same rule for by against height.
- Reset mid-frame: immediate return to reset values. No tlast is owed.

Optional Feature:
- Macro AXIS_TPG_FRAME_TAG_EN.
- Defined: the tuser beat of every frame has lane 0 replaced by frame_cnt zero-extended or truncated to DATA_WIDTH; other lanes are unchanged.
- Undefined: no substitution; tag logic absent.

Decomposition:
- Package axis_tpg_pkg:
  - tpg_mode_e enum with values 0-8.
  - tpg_state_e enum.
  - tpg_cfg_s struct for the latched configuration.
  - Constant BAR_COUNT=8.
- Sub-module axis_tpg_pix: combinational single-lane pattern function (px, py, fc, box, cfg -> pixel), generated CHANNELS times.
- Top module holds the FSM, counters and output registers.

Test Plan:
- W=8, H=2, CHANNELS=2, mode 1, tready=1, HBLANK=VBLANK=0, enable pulse held 1 frame:
  - Expect 8 beats; first beat tdata={16'd1,16'd0} with tuser=1.
  - tlast on beats 4 and 8; frame_cnt=1.
  - Then IDLE, busy=0.
- Mode 1, tready toggled 1010 every cycle: tdata/tlast/tuser stable while stalled; sequence identical to the 1-beat reference; no beat lost or duplicated.
- HBLANK=3, VBLANK=5, H=2: exactly 3 tvalid=0 cycles between lines and 5 between frames; tuser on the first beat of each frame.
- W=5, CHANNELS=2: 3 beats per line; last beat lane1=0, tlast=1.
- tpg_mode changed 1->5 mid-frame: current frame stays a gray ramp; next frame is all ones.
- Reset asserted mid-line:
  - tvalid=0 immediately, frame_cnt=0.
  - After release with enable=1, the first beat has x=0, y=0, tuser=1.

Source files
------------

// File: rtl/axis_tpg_pkg.sv
// axis_tpg_pkg: shared types for the multi-channel AXIS test pattern generator.
// Imported by axis_tpg_pix and axis_tpg_mc.
package axis_tpg_pkg;

  localparam int BAR_COUNT = 8;

  typedef enum logic [3:0] {
    TPG_CHESS = 4'd0,
    TPG_XRAMP = 4'd1,
    TPG_YRAMP = 4'd2,
    TPG_XFC   = 4'd3,
    TPG_YFC   = 4'd4,
    TPG_ONES  = 4'd5,
    TPG_BARS  = 4'd6,
    TPG_FIXED = 4'd7,
    TPG_BOX   = 4'd8
  } tpg_mode_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ACTIVE,
    ST_HBLANK,
    ST_VBLANK
  } tpg_state_e;

  typedef struct packed {
    logic [15:0] width;
    logic [15:0] height;
    logic [15:0] hblank;
    logic [15:0] vblank;
    tpg_mode_e   mode;
  } tpg_cfg_s;

endpackage

// File: rtl/axis_tpg_pix.sv
// axis_tpg_pix: combinational single-lane pattern function.
// Lanes at or beyond the line width produce zero.
module axis_tpg_pix
  import axis_tpg_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int CHESS_WPOW = 4,
  parameter int CHESS_HPOW = 4
) (
  input  logic [16:0]           px,
  input  logic [15:0]           py,
  input  logic [15:0]           fc,
  input  logic [15:0]           bx,
  input  logic [15:0]           by,
  input  logic [15:0]           width,
  input  tpg_mode_e             mode,
  input  logic [DATA_WIDTH-1:0] color,
  output logic [DATA_WIDTH-1:0] pixel
);

  localparam int BAR_BITS = $clog2(BAR_COUNT);
  localparam logic [16:0] BOX_W = 17'(1) << CHESS_WPOW;
  localparam logic [16:0] BOX_H = 17'(1) << CHESS_HPOW;
  localparam logic [DATA_WIDTH-1:0] ONES = '1;

  logic [DATA_WIDTH-1:0] xv;
  logic [DATA_WIDTH-1:0] yv;
  logic [DATA_WIDTH-1:0] fv;
  logic [DATA_WIDTH-1:0] bar_v;
  logic [BAR_BITS-1:0]   bar;
  logic [16:0]           py_w;
  logic [16:0]           bx_w;
  logic [16:0]           by_w;
  logic                  in_box;

  always_comb begin
    xv     = DATA_WIDTH'(px[15:0]);
    yv     = DATA_WIDTH'(py);
    fv     = DATA_WIDTH'(fc);
    bar    = px[CHESS_WPOW +: BAR_BITS];
    bar_v  = DATA_WIDTH'(bar) << (DATA_WIDTH - BAR_BITS);
    py_w   = {1'b0, py};
    bx_w   = {1'b0, bx};
    by_w   = {1'b0, by};
    in_box = (px >= bx_w) && (px < bx_w + BOX_W) &&
             (py_w >= by_w) && (py_w < by_w + BOX_H);
    pixel  = '0;
    if (px < {1'b0, width}) begin
      case (mode)
        TPG_CHESS: pixel = (px[CHESS_WPOW] == py[CHESS_HPOW]) ? ONES : '0;
        TPG_XRAMP: pixel = xv;
        TPG_YRAMP: pixel = yv;
        TPG_XFC:   pixel = xv + fv;
        TPG_YFC:   pixel = yv + fv;
        TPG_ONES:  pixel = ONES;
        TPG_BARS:  pixel = bar_v;
        TPG_FIXED: pixel = color;
        TPG_BOX:   pixel = in_box ? color : '0;
        default:   pixel = '0;
      endcase
    end
  end

endmodule

// File: rtl/axis_tpg_mc.sv
// axis_tpg_mc: AXI4-Stream multi-channel test pattern generator with blanking.
// Define AXIS_TPG_FRAME_TAG_EN to stamp frame_cnt into lane 0 of each tuser beat.
module axis_tpg_mc
  import axis_tpg_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int CHANNELS   = 1,
  parameter int CHESS_WPOW = 4,
  parameter int CHESS_HPOW = 4
) (
  input  logic                           m_axis_aclk,
  input  logic                           rst_n,
  input  logic                           enable,
  input  logic [15:0]                    ACTIVE_WIDTH,
  input  logic [15:0]                    ACTIVE_HEIGHT,
  input  logic [15:0]                    HBLANK,
  input  logic [15:0]                    VBLANK,
  input  logic [3:0]                     tpg_mode,
  input  logic [DATA_WIDTH-1:0]          fixed_color,
  output logic [DATA_WIDTH*CHANNELS-1:0] m_axis_tdata,
  output logic                           m_axis_tlast,
  output logic                           m_axis_tuser,
  output logic                           m_axis_tvalid,
  input  logic                           m_axis_tready,
  output logic [15:0]                    frame_cnt,
  output logic                           busy
);

  localparam logic [15:0] STEP  = 16'(CHANNELS);
  localparam logic [16:0] BOX_W = 17'(1) << CHESS_WPOW;
  localparam logic [16:0] BOX_H = 17'(1) << CHESS_HPOW;

  tpg_state_e                     state;
  tpg_cfg_s                       cfg_q;
  tpg_cfg_s                       cfg_in;
  logic [DATA_WIDTH-1:0]          color_q;
  logic [DATA_WIDTH-1:0]          color_sel;
  logic [15:0]                    width_sel;
  tpg_mode_e                      mode_sel;
  logic [15:0]                    x, y, bx, by, cnt;
  logic [15:0]                    x_nxt, y_nxt, bx_nxt, by_nxt, fc_nxt;
  logic [DATA_WIDTH*CHANNELS-1:0] lanes;
  logic [DATA_WIDTH*CHANNELS-1:0] data_nxt;
  logic hs, eol, eof, last_line, start_ok;
  logic restart, step, nline, load, tlast_nxt;

  assign cfg_in = '{
    width:  ACTIVE_WIDTH,
    height: ACTIVE_HEIGHT,
    hblank: HBLANK,
    vblank: VBLANK,
    mode:   tpg_mode_e'(tpg_mode)
  };

  // Everything below describes the beat that the next edge will present.
  always_comb begin
    hs        = m_axis_tvalid & m_axis_tready;
    eol       = hs & m_axis_tlast;
    last_line = (y == cfg_q.height - 16'd1);
    eof       = eol & last_line;
    start_ok  = enable & (|ACTIVE_WIDTH) & (|ACTIVE_HEIGHT);
    case (state)
      ST_IDLE:   restart = start_ok;
      ST_ACTIVE: restart = eof & (cfg_q.vblank == 16'd0) & start_ok;
      ST_VBLANK: restart = (cnt == 16'd1) & start_ok;
      default:   restart = 1'b0;
    endcase
    step  = hs & ~m_axis_tlast;
    nline = ((state == ST_ACTIVE) & eol & ~last_line &
             (cfg_q.hblank == 16'd0)) |
            ((state == ST_HBLANK) & (cnt == 16'd1));
    load  = restart | step | nline;

    fc_nxt = eof ? frame_cnt + 16'd1 : frame_cnt;
    bx_nxt = bx;
    by_nxt = by;
    if (eof) begin
      bx_nxt = ({1'b0, bx} + 17'd1 + BOX_W > {1'b0, cfg_q.width})
               ? 16'd0 : bx + 16'd1;
      by_nxt = ({1'b0, by} + 17'd1 + BOX_H > {1'b0, cfg_q.height})
               ? 16'd0 : by + 16'd1;
    end

    x_nxt = x;
    y_nxt = y;
    if (restart) begin
      x_nxt = '0;
      y_nxt = '0;
    end else if (step) begin
      x_nxt = x + STEP;
    end else if (eol) begin
      x_nxt = '0;
      y_nxt = last_line ? 16'd0 : y + 16'd1;
    end

    width_sel = restart ? ACTIVE_WIDTH : cfg_q.width;
    mode_sel  = restart ? cfg_in.mode : cfg_q.mode;
    color_sel = restart ? fixed_color : color_q;
    tlast_nxt = ({1'b0, x_nxt} + {1'b0, STEP}) >= {1'b0, width_sel};
  end

  for (genvar k = 0; k < CHANNELS; k++) begin : g_lane
    axis_tpg_pix #(
      .DATA_WIDTH(DATA_WIDTH),
      .CHESS_WPOW(CHESS_WPOW),
      .CHESS_HPOW(CHESS_HPOW)
    ) u_pix (
      .px    ({1'b0, x_nxt} + 17'(k)),
      .py    (y_nxt),
      .fc    (fc_nxt),
      .bx    (bx_nxt),
      .by    (by_nxt),
      .width (width_sel),
      .mode  (mode_sel),
      .color (color_sel),
      .pixel (lanes[k*DATA_WIDTH +: DATA_WIDTH])
    );
  end

  always_comb begin
    data_nxt = lanes;
`ifdef AXIS_TPG_FRAME_TAG_EN
    if (restart) data_nxt[DATA_WIDTH-1:0] = DATA_WIDTH'(fc_nxt);
`endif
  end

  always_ff @(posedge m_axis_aclk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= ST_IDLE;
      cfg_q         <= '0;
      color_q       <= '0;
      x             <= '0;
      y             <= '0;
      bx            <= '0;
      by            <= '0;
      cnt           <= '0;
      frame_cnt     <= '0;
      busy          <= 1'b0;
      m_axis_tdata  <= '0;
      m_axis_tlast  <= 1'b0;
      m_axis_tuser  <= 1'b0;
      m_axis_tvalid <= 1'b0;
    end else begin
      x         <= x_nxt;
      y         <= y_nxt;
      bx        <= bx_nxt;
      by        <= by_nxt;
      frame_cnt <= fc_nxt;
      if (restart) begin
        cfg_q   <= cfg_in;
        color_q <= fixed_color;
      end
      if (load) begin
        m_axis_tvalid <= 1'b1;
        m_axis_tdata  <= data_nxt;
        m_axis_tlast  <= tlast_nxt;
        m_axis_tuser  <= restart;
      end else if (hs) begin
        m_axis_tvalid <= 1'b0;
      end
      case (state)
        ST_IDLE: begin
          if (restart) begin
            state <= ST_ACTIVE;
            busy  <= 1'b1;
          end
        end
        ST_ACTIVE: begin
          if (eof && cfg_q.vblank != 16'd0) begin
            state <= ST_VBLANK;
            cnt   <= cfg_q.vblank;
          end else if (eof && !restart) begin
            state <= ST_IDLE;
            busy  <= 1'b0;
          end else if (eol && !last_line && cfg_q.hblank != 16'd0) begin
            state <= ST_HBLANK;
            cnt   <= cfg_q.hblank;
          end
        end
        ST_HBLANK: begin
          if (cnt == 16'd1) state <= ST_ACTIVE;
          else cnt <= cnt - 16'd1;
        end
        ST_VBLANK: begin
          if (cnt == 16'd1) begin
            state <= restart ? ST_ACTIVE : ST_IDLE;
            busy  <= restart;
          end else begin
            cnt <= cnt - 16'd1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_axis_tpg_mc.sv
// tb_axis_tpg_mc: randomized bench for axis_tpg_mc with two lanes per beat.
// Expected beats come from a frame-level model of the pattern rules.
`timescale 1ns/1ps
module tb_axis_tpg_mc;

  localparam int DW = 16;
  localparam int CH = 2;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              enable;
  logic [15:0]       ACTIVE_WIDTH;
  logic [15:0]       ACTIVE_HEIGHT;
  logic [15:0]       HBLANK;
  logic [15:0]       VBLANK;
  logic [3:0]        tpg_mode;
  logic [DW-1:0]     fixed_color;
  logic [DW*CH-1:0]  m_axis_tdata;
  logic              m_axis_tlast;
  logic              m_axis_tuser;
  logic              m_axis_tvalid;
  logic              m_axis_tready;
  logic [15:0]       frame_cnt;
  logic              busy;

  always #5 clk = ~clk;

  axis_tpg_mc #(
    .DATA_WIDTH(DW),
    .CHANNELS  (CH),
    .CHESS_WPOW(4),
    .CHESS_HPOW(4)
  ) dut (
    .m_axis_aclk  (clk),
    .rst_n        (rst_n),
    .enable       (enable),
    .ACTIVE_WIDTH (ACTIVE_WIDTH),
    .ACTIVE_HEIGHT(ACTIVE_HEIGHT),
    .HBLANK       (HBLANK),
    .VBLANK       (VBLANK),
    .tpg_mode     (tpg_mode),
    .fixed_color  (fixed_color),
    .m_axis_tdata (m_axis_tdata),
    .m_axis_tlast (m_axis_tlast),
    .m_axis_tuser (m_axis_tuser),
    .m_axis_tvalid(m_axis_tvalid),
    .m_axis_tready(m_axis_tready),
    .frame_cnt    (frame_cnt),
    .busy         (busy)
  );

  typedef struct {
    logic [31:0] data;
    logic        last;
    logic        user;
    int          gap;
  } beat_t;

  beat_t q[$];
  int checks = 0;
  int failures = 0;
  int m_fc = 0;
  int m_bx = 0;
  int m_by = 0;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] pat(input int mode, input int px,
                                      input int py, input int fc,
                                      input int bx, input int by,
                                      input logic [15:0] col);
    case (mode)
      0: return (((px / 16) % 2) == ((py / 16) % 2)) ? 16'hffff : 16'h0;
      1: return 16'(px);
      2: return 16'(py);
      3: return 16'(px + fc);
      4: return 16'(py + fc);
      5: return 16'hffff;
      6: return 16'(((px / 16) % 8) * 8192);
      7: return col;
      8: return (px >= bx && px < bx + 16 && py >= by && py < by + 16)
                ? col : 16'h0;
      default: return 16'h0;
    endcase
  endfunction

  task automatic build_frame(input int w, input int h, input int hb,
                             input int vb, input int mode,
                             input logic [15:0] col, input bit is_last);
    for (int yy = 0; yy < h; yy++) begin
      for (int xx = 0; xx < w; xx += CH) begin
        beat_t b;
        b.data = '0;
        for (int k = 0; k < CH; k++)
          if (xx + k < w)
            b.data[k*16 +: 16] = pat(mode, xx + k, yy, m_fc, m_bx, m_by, col);
        b.last = (xx + CH >= w);
        b.user = (xx == 0 && yy == 0);
`ifdef AXIS_TPG_FRAME_TAG_EN
        if (b.user) b.data[15:0] = 16'(m_fc);
`endif
        if (!b.last) b.gap = 0;
        else if (yy < h - 1) b.gap = hb;
        else b.gap = is_last ? -1 : vb;
        q.push_back(b);
      end
    end
    m_fc = (m_fc + 1) % 65536;
    m_bx = (m_bx + 1 + 16 > w) ? 0 : m_bx + 1;
    m_by = (m_by + 1 + 16 > h) ? 0 : m_by + 1;
  endtask

  // rm: 0 = always ready, 1 = alternating, 2 = random
  task automatic run(input int w, input int h, input int hb, input int vb,
                     input int ma, input int mb, input int nf, input int rm);
    logic [15:0] col;
    logic [31:0] pd;
    int cyc, started, gap, exp_gap, waitc;
    bit pend, tu_cnt, pv, pr, pl, pu;
    beat_t e;
    col = 16'($urandom);
    for (int f = 0; f < nf; f++)
      build_frame(w, h, hb, vb, (f == 0) ? ma : mb, col, f == nf - 1);
    @(negedge clk);
    ACTIVE_WIDTH  = 16'(w);
    ACTIVE_HEIGHT = 16'(h);
    HBLANK        = 16'(hb);
    VBLANK        = 16'(vb);
    tpg_mode      = 4'(ma);
    fixed_color   = col;
    m_axis_tready = 1'b1;
    enable        = 1'b1;
    cyc = 0; started = 0; gap = 0; exp_gap = 0;
    pend = 0; tu_cnt = 0; pv = 0; pr = 0; pl = 0; pu = 0; pd = '0;
    while (q.size() > 0 && cyc < 20000) begin
      @(negedge clk);
      cyc++;
      case (rm)
        0: m_axis_tready = 1'b1;
        1: m_axis_tready = (cyc % 2) == 1;
        default: m_axis_tready = 1'($urandom_range(0, 1));
      endcase
      if (cyc == 1) chk("first_lat", 32'(m_axis_tvalid), 32'd1);
      if (pv && !pr) begin
        chk("hold_valid", 32'(m_axis_tvalid), 32'd1);
        chk("hold_data", m_axis_tdata, pd);
        chk("hold_last", 32'(m_axis_tlast), 32'(pl));
        chk("hold_user", 32'(m_axis_tuser), 32'(pu));
      end
      if (pend) begin
        if (!m_axis_tvalid) gap++;
        else begin
          chk("gap", 32'(gap), 32'(exp_gap));
          pend = 0;
        end
      end
      if (m_axis_tvalid && m_axis_tuser && !tu_cnt) begin
        started++;
        tu_cnt = 1;
        if (started == 1) tpg_mode = 4'(mb);
      end
      enable = (started < nf);
      if (m_axis_tvalid && m_axis_tready) begin
        e = q.pop_front();
        chk("tdata", m_axis_tdata, e.data);
        chk("tlast", 32'(m_axis_tlast), 32'(e.last));
        chk("tuser", 32'(m_axis_tuser), 32'(e.user));
        if (m_axis_tuser) tu_cnt = 0;
        pend = 1;
        gap = 0;
        exp_gap = e.gap;
      end
      pv = m_axis_tvalid;
      pr = m_axis_tready;
      pd = m_axis_tdata;
      pl = m_axis_tlast;
      pu = m_axis_tuser;
    end
    chk("beats_left", 32'(q.size()), 32'd0);
    q.delete();
    enable = 1'b0;
    waitc = 0;
    while (busy && waitc < vb + 20) begin
      @(negedge clk);
      waitc++;
    end
    chk("end_busy", 32'(busy), 32'd0);
    chk("end_valid", 32'(m_axis_tvalid), 32'd0);
    chk("end_fcnt", 32'(frame_cnt), 32'(m_fc));
  endtask

  initial begin
    rst_n = 1'b0;
    enable = 1'b0;
    ACTIVE_WIDTH = '0;
    ACTIVE_HEIGHT = '0;
    HBLANK = '0;
    VBLANK = '0;
    tpg_mode = '0;
    fixed_color = '0;
    m_axis_tready = 1'b0;
    #12;
    chk("rst_valid", 32'(m_axis_tvalid), 32'd0);
    chk("rst_last", 32'(m_axis_tlast), 32'd0);
    chk("rst_user", 32'(m_axis_tuser), 32'd0);
    chk("rst_data", m_axis_tdata, 32'd0);
    chk("rst_fcnt", 32'(frame_cnt), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    run(8, 2, 0, 0, 1, 1, 1, 0);
    chk("t1_fcnt", 32'(frame_cnt), 32'd1);
    run(8, 2, 0, 0, 1, 1, 1, 1);
    run(8, 2, 3, 5, 1, 1, 2, 0);
    run(5, 3, 1, 0, 1, 1, 1, 2);
    run(8, 4, 1, 2, 1, 5, 2, 2);
    run(40, 6, 0, 0, 6, 7, 2, 2);
    run(64, 40, 2, 3, 8, 0, 3, 2);

    @(negedge clk);
    ACTIVE_WIDTH = 16'd0;
    ACTIVE_HEIGHT = 16'd4;
    enable = 1'b1;
    repeat (5) @(negedge clk);
    chk("zero_w_busy", 32'(busy), 32'd0);
    chk("zero_w_valid", 32'(m_axis_tvalid), 32'd0);
    enable = 1'b0;

    for (int i = 0; i < 6; i++)
      run($urandom_range(3, 40), $urandom_range(2, 20),
          $urandom_range(0, 4), $urandom_range(0, 4),
          $urandom_range(0, 11), $urandom_range(0, 11), 2, 2);

    @(negedge clk);
    ACTIVE_WIDTH = 16'd16;
    ACTIVE_HEIGHT = 16'd4;
    HBLANK = 16'd0;
    VBLANK = 16'd0;
    tpg_mode = 4'd1;
    m_axis_tready = 1'b1;
    enable = 1'b1;
    repeat (4) @(negedge clk);
    chk("mid_valid", 32'(m_axis_tvalid), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", 32'(m_axis_tvalid), 32'd0);
    chk("mid_rst_fcnt", 32'(frame_cnt), 32'd0);
    chk("mid_rst_busy", 32'(busy), 32'd0);
    enable = 1'b0;
    m_fc = 0;
    m_bx = 0;
    m_by = 0;
    q.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    run(16, 4, 0, 0, 1, 1, 1, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
